// File: rtl/axicb_cpl_switch.sv
`default_nettype none
// ============================================================================
// Module   : axicb_cpl_switch
// Brief    : Routes the granted slave's B/R completion beats to the master, or
//            generates a local DECERR completion for misrouted requests.
// Revision : 1.0 - initial release
// ============================================================================
module axicb_cpl_switch #(
    parameter int AXI_ID_W = 8,
    parameter int SLV_NB   = 4,
    // Payload holds RESP + ID + data, so it must be at least AXI_ID_W+2 wide
    parameter int CCH_W    = 16,
    parameter int RD_MODE  = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    srst,
    input  logic                    g_valid,
    output logic                    g_ready,
    input  logic [AXI_ID_W-1:0]     g_id,
    input  logic [7:0]              g_len,
    input  logic [SLV_NB-1:0]       g_ix,
    input  logic                    g_mr,
    input  logic [SLV_NB-1:0]       s_valid,
    output logic [SLV_NB-1:0]       s_ready,
    input  logic [SLV_NB-1:0]       s_last,
    input  logic [CCH_W*SLV_NB-1:0] s_ch,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [CCH_W-1:0]        m_ch,
    output logic                    len_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_MR   = 2'd2;

    logic [1:0]          r_state;
    logic [AXI_ID_W-1:0] r_id;
    logic [SLV_NB-1:0]   r_ix;
    logic [7:0]          r_cnt;

    logic                w_cnt_zero;
    logic                w_beat;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [CCH_W-1:0]    w_sel_ch;
    logic [CCH_W-1:0]    w_mr_ch;

    assign w_cnt_zero = (r_cnt == 8'd0);
    assign w_beat     = m_valid && m_ready;

    // One-hot AND-OR mux; r_ix is guaranteed one-hot whenever FWD is entered
    always_comb begin : p_sel
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_ch    = '0;
        for (int i = 0; i < SLV_NB; i++) begin
            if (r_ix[i]) begin
                w_sel_valid = w_sel_valid | s_valid[i];
                w_sel_last  = w_sel_last  | s_last[i];
                w_sel_ch    = w_sel_ch    | s_ch[i*CCH_W +: CCH_W];
            end
        end
    end

    always_comb begin : p_mr_ch
        w_mr_ch                 = '0;
        w_mr_ch[AXI_ID_W+1:2]   = r_id;
        w_mr_ch[1:0]            = 2'b11;
    end

    always_ff @(posedge aclk or negedge aresetn) begin : p_fsm
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_id    <= '0;
            r_ix    <= '0;
        end else if (srst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_id    <= '0;
            r_ix    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (g_valid) begin
                        r_id    <= g_id;
                        r_ix    <= g_ix;
                        r_cnt   <= (RD_MODE != 0) ? g_len : 8'd0;
                        // Zero or multi-hot targets cannot be routed safely
                        r_state <= (g_mr || !$onehot(g_ix)) ? S_MR : S_FWD;
                    end
                end
                S_FWD, S_MR: begin
                    if (w_beat) begin
                        if (w_cnt_zero) r_state <= S_IDLE;
                        else            r_cnt   <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A grant is never pulled while the synchronous reset is asserted
    always_comb begin : p_out
        g_ready = (r_state == S_IDLE) && !srst;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_ch    = '0;
        s_ready = '0;
        len_err = 1'b0;
        case (r_state)
            S_FWD: begin
                m_valid = w_sel_valid;
                m_ch    = w_sel_ch;
                m_last  = w_cnt_zero;
                s_ready = r_ix & {SLV_NB{m_ready}};
                len_err = (RD_MODE != 0) && w_sel_valid && m_ready &&
                          (w_sel_last != w_cnt_zero);
            end
            S_MR: begin
                m_valid = 1'b1;
                m_ch    = w_mr_ch;
                m_last  = w_cnt_zero;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axicb_cpl_switch.sv
`default_nettype none
// ============================================================================
// Module   : tb_axicb_cpl_switch
// Brief    : Self-checking bench for axicb_cpl_switch (write and read variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axicb_cpl_switch;

    localparam int c_cw = 16;

    logic        clk;
    logic        r_rst_n, r_srst, r_g_valid, r_g_mr, r_m_ready;
    logic [7:0]  r_g_id, r_g_len;
    logic [3:0]  r_g_ix, r_s_valid, r_s_last;
    logic [63:0] r_s_ch;

    logic        w_wr_g_ready, w_wr_m_valid, w_wr_m_last, w_wr_len_err;
    logic [3:0]  w_wr_s_ready;
    logic [15:0] w_wr_m_ch;
    logic        w_rd_g_ready, w_rd_m_valid, w_rd_m_last, w_rd_len_err;
    logic [3:0]  w_rd_s_ready;
    logic [15:0] w_rd_m_ch;

    int errors = 0;
    int checks = 0;

    axicb_cpl_switch #(.AXI_ID_W(8), .SLV_NB(4), .CCH_W(c_cw), .RD_MODE(0)) u_wr (
        .aclk(clk), .aresetn(r_rst_n), .srst(r_srst),
        .g_valid(r_g_valid), .g_ready(w_wr_g_ready), .g_id(r_g_id), .g_len(r_g_len),
        .g_ix(r_g_ix), .g_mr(r_g_mr),
        .s_valid(r_s_valid), .s_ready(w_wr_s_ready), .s_last(r_s_last), .s_ch(r_s_ch),
        .m_valid(w_wr_m_valid), .m_ready(r_m_ready), .m_last(w_wr_m_last),
        .m_ch(w_wr_m_ch), .len_err(w_wr_len_err)
    );

    axicb_cpl_switch #(.AXI_ID_W(8), .SLV_NB(4), .CCH_W(c_cw), .RD_MODE(1)) u_rd (
        .aclk(clk), .aresetn(r_rst_n), .srst(r_srst),
        .g_valid(r_g_valid), .g_ready(w_rd_g_ready), .g_id(r_g_id), .g_len(r_g_len),
        .g_ix(r_g_ix), .g_mr(r_g_mr),
        .s_valid(r_s_valid), .s_ready(w_rd_s_ready), .s_last(r_s_last), .s_ch(r_s_ch),
        .m_valid(w_rd_m_valid), .m_ready(r_m_ready), .m_last(w_rd_m_last),
        .m_ch(w_rd_m_ch), .len_err(w_rd_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected read-side outputs: {valid, last, len_err, s_ready, payload}
    typedef struct packed {
        logic        valid;
        logic        last;
        logic        lerr;
        logic [3:0]  srdy;
        logic [15:0] ch;
    } exp_t;

    typedef struct {
        logic [7:0] id;
        logic [7:0] len;
        logic [3:0] ix;
        logic       mr;
    } grant_t;

    // Reference: beat 'done' of an nbeats completion for the given grant
    function automatic exp_t model(input logic [7:0] id, input logic [3:0] ix,
                                   input logic mr, input int done, input int nbeats);
        exp_t e;
        int   k;
        k = 0;
        for (int i = 0; i < 4; i++) if (ix[i]) k = i;
        e.last = (done == nbeats - 1);
        if (mr || ($countones(ix) != 1)) begin
            e.valid = 1'b1;
            e.ch    = {6'd0, id, 2'b11};
            e.srdy  = 4'd0;
            e.lerr  = 1'b0;
        end else begin
            e.valid = r_s_valid[k];
            e.ch    = r_s_ch[k*c_cw +: c_cw];
            e.srdy  = ix & {4{r_m_ready}};
            e.lerr  = e.valid && r_m_ready && (r_s_last[k] != e.last);
        end
        return e;
    endfunction

    function automatic exp_t rd_obs();
        return {w_rd_m_valid, w_rd_m_last, w_rd_len_err, w_rd_s_ready, w_rd_m_ch};
    endfunction

    task automatic rand_slaves();
        r_s_valid = 4'($urandom);
        r_s_last  = 4'($urandom);
        r_s_ch    = {$urandom, $urandom};
    endtask

    task automatic set_grant(input logic [7:0] id, input logic [7:0] len,
                             input logic [3:0] ix, input logic mr);
        r_g_valid = 1'b1;
        r_g_id    = id;
        r_g_len   = len;
        r_g_ix    = ix;
        r_g_mr    = mr;
    endtask

    task automatic clear_state();
        @(negedge clk);
        r_g_valid = 1'b0;
        r_srst    = 1'b1;
        @(negedge clk);
        r_srst    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rand_slaves();
        r_m_ready = 1'b1;
        #1;
        checks++;
        if ({w_rd_g_ready, w_rd_m_valid, w_rd_m_last, w_rd_len_err, w_rd_s_ready, w_rd_m_ch} !== 24'h80_0000) begin
            errors++;
            $display("FAIL reset_rd: got %b%b%b%b %h %h required 1000 0 0000", w_rd_g_ready,
                     w_rd_m_valid, w_rd_m_last, w_rd_len_err, w_rd_s_ready, w_rd_m_ch);
        end
        checks++;
        if ({w_wr_g_ready, w_wr_m_valid, w_wr_m_last, w_wr_len_err, w_wr_s_ready, w_wr_m_ch} !== 24'h80_0000) begin
            errors++;
            $display("FAIL reset_wr: got %b%b%b%b %h %h required 1000 0 0000", w_wr_g_ready,
                     w_wr_m_valid, w_wr_m_last, w_wr_len_err, w_wr_s_ready, w_wr_m_ch);
        end
        @(negedge clk);
        r_rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({w_rd_g_ready, w_rd_m_valid, w_rd_s_ready} !== 6'b100000) begin
            errors++;
            $display("FAIL idle_after_reset: got g_ready=%b m_valid=%b s_ready=%b required 1 0 0000",
                     w_rd_g_ready, w_rd_m_valid, w_rd_s_ready);
        end
    endtask

    task automatic test_write_single();
        logic [15:0] pay;
        pay = {6'($urandom), 8'd5, 2'b00};
        @(negedge clk);
        r_s_valid = 4'b0010;
        r_s_last  = 4'b0000;
        r_s_ch    = {$urandom, $urandom};
        r_s_ch[31:16] = pay;
        r_m_ready = 1'b1;
        set_grant(8'd5, 8'd0, 4'b0010, 1'b0);
        #1;
        checks++;
        if ({w_wr_g_ready, w_wr_m_valid} !== 2'b10) begin
            errors++;
            $display("FAIL wr_idle_grant: got g_ready=%b m_valid=%b required 1 0", w_wr_g_ready, w_wr_m_valid);
        end
        @(negedge clk);
        r_g_valid = 1'b0;
        #1;
        checks++;
        if ({w_wr_m_valid, w_wr_m_last, w_wr_s_ready, w_wr_m_ch} !== {1'b1, 1'b1, 4'b0010, pay}) begin
            errors++;
            $display("FAIL wr_beat: got v=%b l=%b rdy=%b ch=%h required 1 1 0010 %h",
                     w_wr_m_valid, w_wr_m_last, w_wr_s_ready, w_wr_m_ch, pay);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({w_wr_g_ready, w_wr_m_valid} !== 2'b10) begin
            errors++;
            $display("FAIL wr_back_idle: got g_ready=%b m_valid=%b required 1 0", w_wr_g_ready, w_wr_m_valid);
        end
    endtask

    task automatic test_read_burst();
        logic [7:0] id;
        int done, cyc;
        exp_t e;
        id = 8'($urandom);
        @(negedge clk);
        set_grant(id, 8'd3, 4'b0100, 1'b0);
        #1;
        @(negedge clk);
        r_g_valid = 1'b0;
        done = 0;
        cyc  = 0;
        while (done < 4 && cyc < 200) begin
            rand_slaves();
            r_m_ready = (cyc % 2 == 0);
            #1;
            e = model(id, 4'b0100, 1'b0, done, 4);
            checks++;
            if (rd_obs() !== e) begin
                errors++;
                $display("FAIL rd_burst beat%0d: got %h required %h", done, rd_obs(), e);
            end
            if (e.valid && r_m_ready) done++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (done != 4) begin
            errors++;
            $display("FAIL rd_burst_timeout: got %0d beats required 4", done);
        end
        #1;
        checks++;
        if ({w_rd_g_ready, w_rd_m_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rd_burst_end: got g_ready=%b m_valid=%b required 1 0", w_rd_g_ready, w_rd_m_valid);
        end
    endtask

    task automatic test_misrouted();
        int done, cyc;
        exp_t e;
        @(negedge clk);
        set_grant(8'h2A, 8'd1, 4'($urandom), 1'b1);
        #1;
        @(negedge clk);
        r_g_valid = 1'b0;
        done = 0;
        cyc  = 0;
        while (done < 2 && cyc < 100) begin
            rand_slaves();
            r_m_ready = 1'($urandom);
            #1;
            e = model(8'h2A, r_g_ix, 1'b1, done, 2);
            checks++;
            if (rd_obs() !== e) begin
                errors++;
                $display("FAIL mr beat%0d: got %h required %h", done, rd_obs(), e);
            end
            if (e.valid && r_m_ready) done++;
            cyc++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (done != 2 || w_rd_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_end: got %0d beats m_valid=%b required 2 0", done, w_rd_m_valid);
        end
    endtask

    task automatic test_len_err();
        int pulses;
        exp_t e;
        pulses = 0;
        @(negedge clk);
        set_grant(8'h11, 8'd2, 4'b0001, 1'b0);
        #1;
        @(negedge clk);
        r_g_valid = 1'b0;
        r_m_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            r_s_valid = 4'b1111;
            r_s_ch    = {$urandom, $urandom};
            // Slave signals last early on beat 2 and keeps it on beat 3
            r_s_last  = (b >= 1) ? 4'b1111 : 4'b0000;
            #1;
            e = model(8'h11, 4'b0001, 1'b0, b, 3);
            checks++;
            if (rd_obs() !== e) begin
                errors++;
                $display("FAIL len_err beat%0d: got %h required %h", b, rd_obs(), e);
            end
            if (w_rd_len_err === 1'b1) pulses++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (pulses != 1 || w_rd_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL len_err_count: got %0d pulses m_valid=%b required 1 0", pulses, w_rd_m_valid);
        end
    endtask

    task automatic test_max_len();
        int done, cyc;
        exp_t e;
        @(negedge clk);
        set_grant(8'hC3, 8'd255, 4'b1000, 1'b0);
        #1;
        @(negedge clk);
        r_g_valid = 1'b0;
        r_m_ready = 1'b1;
        done = 0;
        cyc  = 0;
        while (done < 256 && cyc < 1000) begin
            rand_slaves();
            #1;
            e = model(8'hC3, 4'b1000, 1'b0, done, 256);
            checks++;
            if (rd_obs() !== e) begin
                errors++;
                $display("FAIL max_len beat%0d: got %h required %h", done, rd_obs(), e);
            end
            if (e.valid && r_m_ready) done++;
            cyc++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (done != 256 || w_rd_g_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_len_end: got %0d beats g_ready=%b required 256 1", done, w_rd_g_ready);
        end
    endtask

    task automatic test_srst();
        int done, cyc;
        exp_t e;
        @(negedge clk);
        set_grant(8'h40, 8'd7, 4'b0100, 1'b0);
        r_s_valid = 4'b1111;
        r_m_ready = 1'b1;
        @(negedge clk);
        r_g_valid = 1'b0;
        #1;
        checks++;
        if (w_rd_m_valid !== 1'b1) begin
            errors++;
            $display("FAIL srst_beat1: got m_valid=%b required 1", w_rd_m_valid);
        end
        @(negedge clk);
        r_srst = 1'b1;
        @(negedge clk);
        r_srst = 1'b0;
        #1;
        checks++;
        if ({w_rd_g_ready, w_rd_m_valid, w_rd_s_ready, w_rd_m_last} !== 7'b1000000) begin
            errors++;
            $display("FAIL srst_abort: got g_ready=%b m_valid=%b s_ready=%b m_last=%b required 1 0 0000 0",
                     w_rd_g_ready, w_rd_m_valid, w_rd_s_ready, w_rd_m_last);
        end
        @(negedge clk);
        r_srst = 1'b1;
        set_grant(8'h01, 8'd0, 4'b0001, 1'b0);
        #1;
        checks++;
        if (w_rd_g_ready !== 1'b0) begin
            errors++;
            $display("FAIL srst_no_pull: got g_ready=%b required 0", w_rd_g_ready);
        end
        @(negedge clk);
        r_srst    = 1'b0;
        r_g_valid = 1'b0;
        #1;
        checks++;
        if ({w_rd_m_valid, w_rd_s_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL srst_no_latch: got m_valid=%b s_ready=%b required 0 0000", w_rd_m_valid, w_rd_s_ready);
        end
        @(negedge clk);
        set_grant(8'h77, 8'd1, 4'b0010, 1'b0);
        #1;
        checks++;
        if (w_rd_g_ready !== 1'b1) begin
            errors++;
            $display("FAIL srst_regrant: got g_ready=%b required 1", w_rd_g_ready);
        end
        @(negedge clk);
        r_g_valid = 1'b0;
        done = 0;
        cyc  = 0;
        while (done < 2 && cyc < 100) begin
            rand_slaves();
            r_m_ready = 1'($urandom);
            #1;
            e = model(8'h77, 4'b0010, 1'b0, done, 2);
            checks++;
            if (rd_obs() !== e) begin
                errors++;
                $display("FAIL srst_next beat%0d: got %h required %h", done, rd_obs(), e);
            end
            if (e.valid && r_m_ready) done++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (done != 2) begin
            errors++;
            $display("FAIL srst_next_timeout: got %0d beats required 2", done);
        end
    endtask

    // Grant FIFO model: one grant per idle cycle, one bubble between completions
    task automatic test_back_to_back();
        grant_t q[$];
        grant_t g, cur;
        int     gi, done, cyc, n;
        logic   active;
        exp_t   e;
        g = '{id: 8'h10, len: 8'd2, ix: 4'b0001, mr: 1'b0}; q.push_back(g);
        g = '{id: 8'h13, len: 8'd1, ix: 4'b1000, mr: 1'b0}; q.push_back(g);
        for (int i = 0; i < 10; i++) begin
            g.id  = 8'($urandom);
            g.len = 8'($urandom_range(0, 4));
            g.ix  = 4'($urandom);
            g.mr  = ($urandom_range(0, 4) == 0);
            q.push_back(g);
        end
        gi = 0; active = 1'b0; done = 0; cyc = 0; n = 0;
        cur = q[0];
        while ((gi < q.size() || active) && cyc < 2000) begin
            @(negedge clk);
            if (!active && gi < q.size()) set_grant(q[gi].id, q[gi].len, q[gi].ix, q[gi].mr);
            else r_g_valid = 1'b0;
            if (gi <= 2) begin
                r_s_valid = 4'b1111;
                r_s_last  = 4'b0000;
                r_s_ch    = {$urandom, $urandom};
                r_m_ready = 1'b1;
            end else begin
                rand_slaves();
                r_m_ready = 1'($urandom);
            end
            #1;
            if (!active) begin
                checks++;
                if ({w_rd_g_ready, w_rd_m_valid, w_rd_s_ready} !== 6'b100000) begin
                    errors++;
                    $display("FAIL b2b_idle g%0d: got g_ready=%b m_valid=%b s_ready=%b required 1 0 0000",
                             gi, w_rd_g_ready, w_rd_m_valid, w_rd_s_ready);
                end
                if (gi < q.size()) begin
                    cur = q[gi]; gi++; active = 1'b1; done = 0; n = int'(cur.len) + 1;
                end
            end else begin
                e = model(cur.id, cur.ix, cur.mr, done, n);
                checks++;
                if ({w_rd_g_ready, rd_obs()} !== {1'b0, e}) begin
                    errors++;
                    $display("FAIL b2b g%0d beat%0d: got %b_%h required 0_%h",
                             gi - 1, done, w_rd_g_ready, rd_obs(), e);
                end
                if (e.valid && r_m_ready) begin
                    done++;
                    if (done == n) active = 1'b0;
                end
            end
            cyc++;
        end
        checks++;
        if (active || gi != q.size()) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d grants done required %0d", gi, q.size());
        end
    endtask

    initial begin
        r_rst_n = 1'b0; r_srst = 1'b0; r_g_valid = 1'b0; r_g_mr = 1'b0; r_m_ready = 1'b0;
        r_g_id = 8'd0; r_g_len = 8'd0; r_g_ix = 4'd0;
        r_s_valid = 4'd0; r_s_last = 4'd0; r_s_ch = 64'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write_single();
        clear_state();
        test_read_burst();
        clear_state();
        test_misrouted();
        clear_state();
        test_len_err();
        clear_state();
        test_max_len();
        clear_state();
        test_srst();
        clear_state();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
